alu_operand_bank: RTL and testbench

// Parametrised operand register bank and registered operand selector for the GF(2^m) ALU.
// - Holds NREGS field-element registers written back from the ALU.
// - Per request, picks two operands (from the bank or the curve constant g) and optionally swaps them.
// - Presents the pair to the ALU through a one-entry valid/ready output stage.

---
 rtl/alu_operand_bank_if.sv | 27 ++
 rtl/alu_operand_bank.sv | 95 +++++++++
 tb/tb_alu_operand_bank.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_bank_if.sv
// Operand request and ALU-side handshake for alu_operand_bank.
// The master issues operand requests and consumes the pair; the slave is the bank.
interface alu_operand_bank_if #(
    parameter int unsigned WIDTH = 163,
    parameter int unsigned SELW  = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [SELW-1:0]  sel_x;
    logic [SELW-1:0]  sel_z;
    logic             swap;
    logic             alu_valid;
    logic             alu_ready;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_z;
    logic             err_sel;

    modport master (
        output req_valid, sel_x, sel_z, swap, alu_ready,
        input  req_ready, alu_valid, alu_x, alu_z, err_sel
    );

    modport slave (
        input  req_valid, sel_x, sel_z, swap, alu_ready,
        output req_ready, alu_valid, alu_x, alu_z, err_sel
    );
endinterface

// File: rtl/alu_operand_bank.sv
// Operand register bank for the GF(2^m) ALU: NREGS write-back registers plus curve constant g,
// with a registered, swappable operand pair behind a one-entry valid/ready stage.
module alu_operand_bank #(
    parameter int unsigned WIDTH = 163,
    parameter int unsigned NREGS = 8,
    parameter int unsigned SELW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g_in,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    alu_operand_bank_if.slave bus
);
    localparam logic [SELW-1:0] GSEL = SELW'(NREGS);

    logic [WIDTH-1:0] bank_q   [NREGS];
    logic [WIDTH-1:0] bank_fwd [NREGS];
    logic [WIDTH-1:0] src_x, src_z;
    logic [WIDTH-1:0] alu_x_q, alu_x_d, alu_z_q, alu_z_d;
    logic             alu_valid_q, alu_valid_d;
    logic             err_q, err_d;
    logic             req_ready, accept, illegal;

    // Forward a same-cycle write so an accepted request sees the new value.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            bank_fwd[i] = (wr_en && (wr_addr == SELW'(i))) ? wr_data : bank_q[i];
        end
    end

    // Indices above NREGS are illegal and read as zero.
    always_comb begin
        src_x = '0;
        src_z = '0;
        if (bus.sel_x == GSEL) src_x = g_in;
        if (bus.sel_z == GSEL) src_z = g_in;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (bus.sel_x == SELW'(i)) src_x = bank_fwd[i];
            if (bus.sel_z == SELW'(i)) src_z = bank_fwd[i];
        end
    end

    assign illegal   = (bus.sel_x > GSEL) || (bus.sel_z > GSEL);
    assign req_ready = !alu_valid_q || bus.alu_ready;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        alu_x_d     = alu_x_q;
        alu_z_d     = alu_z_q;
        alu_valid_d = alu_valid_q;
        err_d       = 1'b0;
        if (accept) begin
            alu_x_d     = bus.swap ? src_z : src_x;
            alu_z_d     = bus.swap ? src_x : src_z;
            alu_valid_d = 1'b1;
            err_d       = illegal;
        end else if (bus.alu_ready) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_en && (wr_addr == SELW'(i))) bank_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x_q     <= '0;
            alu_z_q     <= '0;
            alu_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            alu_x_q     <= alu_x_d;
            alu_z_q     <= alu_z_d;
            alu_valid_q <= alu_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.alu_valid = alu_valid_q;
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_z     = alu_z_q;
    assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_alu_operand_bank.sv
// Self-checking bench for alu_operand_bank: directed vector table, reset/readback sequence,
// then randomized traffic against a behavioural model of the bank and output stage.
module tb_alu_operand_bank;
    localparam int unsigned W = 163;

    typedef struct {
        logic         we;
        logic [3:0]   wa;
        logic [W-1:0] wd;
        logic         rv;
        logic [3:0]   sx;
        logic [3:0]   sz;
        logic         sw;
        logic         ar;
        logic [W-1:0] g;
        logic         exp_rr;
        logic         exp_v;
        logic [W-1:0] exp_x;
        logic [W-1:0] exp_z;
        logic         exp_e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] g_in = '0;
    logic         wr_en = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [W-1:0] m_bank [8];
    logic [W-1:0] m_x, m_z;
    logic         m_valid, m_err;

    alu_operand_bank_if #(.WIDTH(W), .SELW(4)) bus ();

    alu_operand_bank #(.WIDTH(W), .NREGS(8), .SELW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g_in    (g_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [W-1:0] wd, logic rv,
                                logic [3:0] sx, logic [3:0] sz, logic sw, logic ar,
                                logic [W-1:0] g, logic rr, logic ev, logic [W-1:0] ex,
                                logic [W-1:0] ez, logic ee);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.sx = sx; v.sz = sz; v.sw = sw;
        v.ar = ar; v.g = g; v.exp_rr = rr; v.exp_v = ev; v.exp_x = ex; v.exp_z = ez;
        v.exp_e = ee;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = '0;
        m_x = '0; m_z = '0; m_valid = 1'b0; m_err = 1'b0;
    endfunction

    function automatic logic [W-1:0] model_src(input int s);
        if (s < 8) return (wr_en && int'(wr_addr) == s) ? wr_data : m_bank[s];
        if (s == 8) return g_in;
        return '0;
    endfunction

    function automatic logic model_ready();
        return !m_valid || bus.alu_ready;
    endfunction

    // Applies one clock edge of the rules to the model, using the inputs currently driven.
    function automatic void model_step();
        logic [W-1:0] a, b;
        if (bus.req_valid && model_ready()) begin
            a = model_src(int'(bus.sel_x));
            b = model_src(int'(bus.sel_z));
            m_x = bus.swap ? b : a;
            m_z = bus.swap ? a : b;
            m_valid = 1'b1;
            m_err = (bus.sel_x > 4'd8) || (bus.sel_z > 4'd8);
        end else begin
            m_err = 1'b0;
            if (bus.alu_ready) m_valid = 1'b0;
        end
        if (wr_en && wr_addr < 4'd8) m_bank[wr_addr[2:0]] = wr_data;
    endfunction

    task automatic drive(input vec_t v);
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; g_in = v.g;
        bus.req_valid = v.rv; bus.sel_x = v.sx; bus.sel_z = v.sz; bus.swap = v.sw;
        bus.alu_ready = v.ar;
    endtask

    // Called at a negedge with inputs driven; ends at the following negedge.
    task automatic step_model_check(input string tag);
        #1 check({tag, " req_ready"}, W'(bus.req_ready), W'(model_ready()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check({tag, " alu_valid"}, W'(bus.alu_valid), W'(m_valid));
        check({tag, " alu_x"}, bus.alu_x, m_x);
        check({tag, " alu_z"}, bus.alu_z, m_z);
        check({tag, " err_sel"}, W'(bus.err_sel), W'(m_err));
    endtask

    vec_t vecs[19];
    vec_t v;

    initial begin
        bus.req_valid = 1'b0; bus.sel_x = '0; bus.sel_z = '0; bus.swap = 1'b0;
        bus.alu_ready = 1'b1;
        model_reset();
        #3;
        check("reset alu_valid", W'(bus.alu_valid), '0);
        check("reset alu_x", bus.alu_x, '0);
        check("reset err_sel", W'(bus.err_sel), '0);
        @(negedge clk);
        rst_n = 1'b1;

        //            we wa wd       rv sx  sz sw ar g       rr v  x       z       e
        vecs[0]  = mk(1, 2, W'(5),   0, 0,  0, 0, 1, '0,     1, 0, '0,     '0,     0);
        vecs[1]  = mk(1, 5, W'('hA), 0, 0,  0, 0, 1, '0,     1, 0, '0,     '0,     0);
        vecs[2]  = mk(0, 0, '0,      1, 2,  5, 0, 1, '0,     1, 1, W'(5),  W'('hA), 0);
        vecs[3]  = mk(0, 0, '0,      1, 8,  2, 1, 1, W'('h1F), 1, 1, W'(5), W'('h1F), 0);
        vecs[4]  = mk(1, 3, W'('h77), 1, 3, 3, 0, 1, '0,     1, 1, W'('h77), W'('h77), 0);
        vecs[5]  = mk(0, 0, '0,      1, 12, 2, 0, 1, '0,     1, 1, '0,     W'(5),  1);
        vecs[6]  = mk(0, 0, '0,      0, 0,  0, 0, 1, '0,     1, 0, '0,     W'(5),  0);
        vecs[7]  = mk(1, 9, W'('hFFF), 0, 0, 0, 0, 1, '0,    1, 0, '0,     W'(5),  0);
        vecs[8]  = mk(0, 0, '0,      1, 2,  5, 0, 0, '0,     1, 1, W'(5),  W'('hA), 0);
        for (int i = 9; i < 13; i++)
            vecs[i] = mk(0, 0, '0,   1, 3,  2, 0, 0, '0,     0, 1, W'(5),  W'('hA), 0);
        vecs[13] = mk(0, 0, '0,      1, 3,  2, 0, 1, '0,     1, 1, W'('h77), W'(5), 0);
        vecs[14] = mk(0, 0, '0,      1, 0,  1, 0, 1, '0,     1, 1, '0,     '0,     0);
        vecs[15] = mk(0, 0, '0,      1, 6,  7, 1, 1, '0,     1, 1, '0,     '0,     0);
        vecs[16] = mk(0, 0, '0,      0, 0,  0, 0, 1, '0,     1, 0, '0,     '0,     0);
        vecs[17] = mk(0, 0, '0,      1, 8, 13, 0, 1, W'('h3C), 1, 1, W'('h3C), '0,  1);
        vecs[18] = mk(0, 0, '0,      0, 0,  0, 0, 1, '0,     1, 0, W'('h3C), '0,    0);

        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            drive(v);
            #1 check($sformatf("vec%0d req_ready", i), W'(bus.req_ready), W'(v.exp_rr));
            @(posedge clk);
            model_step();
            @(negedge clk);
            check($sformatf("vec%0d alu_valid", i), W'(bus.alu_valid), W'(v.exp_v));
            check($sformatf("vec%0d alu_x", i), bus.alu_x, v.exp_x);
            check($sformatf("vec%0d alu_z", i), bus.alu_z, v.exp_z);
            check($sformatf("vec%0d err_sel", i), W'(bus.err_sel), W'(v.exp_e));
        end

        // Mid-stream reset while a pair is held under backpressure.
        drive(mk(0, 0, '0, 1, 3, 4, 0, 0, '0, 0, 0, '0, '0, 0));
        step_model_check("pre-reset");
        check("pre-reset held valid", W'(bus.alu_valid), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async reset alu_valid", W'(bus.alu_valid), '0);
        check("async reset alu_x", bus.alu_x, '0);
        check("async reset alu_z", bus.alu_z, '0);
        check("async reset err_sel", W'(bus.err_sel), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(mk(0, 0, '0, 1, 4'(i), 4'(i), 0, 1, rand_w(), 1, 1, '0, '0, 0));
            step_model_check($sformatf("readback reg%0d", i));
            check($sformatf("reg%0d cleared", i), bus.alu_x, '0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            wr_en = ($urandom_range(0, 1) == 1);
            wr_addr = 4'($urandom_range(0, 9));
            wr_data = rand_w();
            g_in = rand_w();
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.sel_x = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 8));
            bus.sel_z = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 8));
            bus.swap = ($urandom_range(0, 1) == 1);
            bus.alu_ready = ($urandom_range(0, 9) < 6);
            step_model_check($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
